// File: rtl/tlb_port_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_port_sched_if
// Description : Request, response and TLB-facing signal bundle for the
//               TLB port scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_port_sched_if #(
    parameter int ASID_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
);
    // flush front-end
    logic                    flush_req_i;
    logic [ASID_WIDTH-1:0]   flush_asid_i;
    logic [31:0]             flush_vaddr_i;
    logic                    flush_done_o;
    // PTW update
    logic                    upd_valid_i;
    logic                    upd_ready_o;
    logic                    upd_is_4M_i;
    logic [19:0]             upd_vpn_i;
    logic [8:0]              upd_asid_i;
    logic [31:0]             upd_content_i;
    // lookup clients
    logic [1:0]              lu_valid_i;
    logic [1:0]              lu_ready_o;
    logic [63:0]             lu_vaddr_i;
    logic [2*ASID_WIDTH-1:0] lu_asid_i;
    logic                    resp_valid_o;
    logic                    resp_id_o;
    logic                    resp_hit_o;
    logic                    resp_is_4M_o;
    logic [31:0]             resp_content_o;
    // TLB side
    logic                    tlb_flush_o;
    logic [62:0]             tlb_update_o;
    logic                    tlb_lu_access_o;
    logic [ASID_WIDTH-1:0]   tlb_lu_asid_o;
    logic [31:0]             tlb_lu_vaddr_o;
    logic [ASID_WIDTH-1:0]   tlb_asid_to_be_flushed_o;
    logic [31:0]             tlb_vaddr_to_be_flushed_o;
    logic                    tlb_lu_hit_i;
    logic                    tlb_lu_is_4M_i;
    logic [31:0]             tlb_lu_content_i;
    // performance counters
    logic [CNT_WIDTH-1:0]    hit_cnt_o;
    logic [CNT_WIDTH-1:0]    miss_cnt_o;

    modport slave (
        input  flush_req_i, flush_asid_i, flush_vaddr_i,
        output flush_done_o,
        input  upd_valid_i, upd_is_4M_i, upd_vpn_i, upd_asid_i, upd_content_i,
        output upd_ready_o,
        input  lu_valid_i, lu_vaddr_i, lu_asid_i,
        output lu_ready_o,
        output resp_valid_o, resp_id_o, resp_hit_o, resp_is_4M_o, resp_content_o,
        output tlb_flush_o, tlb_update_o, tlb_lu_access_o, tlb_lu_asid_o,
        output tlb_lu_vaddr_o, tlb_asid_to_be_flushed_o, tlb_vaddr_to_be_flushed_o,
        input  tlb_lu_hit_i, tlb_lu_is_4M_i, tlb_lu_content_i,
        output hit_cnt_o, miss_cnt_o
    );

    modport master (
        output flush_req_i, flush_asid_i, flush_vaddr_i,
        input  flush_done_o,
        output upd_valid_i, upd_is_4M_i, upd_vpn_i, upd_asid_i, upd_content_i,
        input  upd_ready_o,
        output lu_valid_i, lu_vaddr_i, lu_asid_i,
        input  lu_ready_o,
        input  resp_valid_o, resp_id_o, resp_hit_o, resp_is_4M_o, resp_content_o,
        input  tlb_flush_o, tlb_update_o, tlb_lu_access_o, tlb_lu_asid_o,
        input  tlb_lu_vaddr_o, tlb_asid_to_be_flushed_o, tlb_vaddr_to_be_flushed_o,
        output tlb_lu_hit_i, tlb_lu_is_4M_i, tlb_lu_content_i,
        input  hit_cnt_o, miss_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/tlb_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tlb_port_sched
// Description : Serialises flush, PTW update and two lookup clients onto the
//               single port of the TLB, with saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_port_sched #(
    parameter int ASID_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    tlb_port_sched_if.slave bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FLUSH  = 2'd1;
    localparam logic [1:0] c_UPDATE = 2'd2;
    localparam logic [1:0] c_LOOKUP = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]            r_state;
    logic                  r_flush_pend;
    logic [ASID_WIDTH-1:0] r_flush_asid;
    logic [31:0]           r_flush_vaddr;
    logic                  r_rr_ptr;

    logic                  r_cmd_is_4M;
    logic [19:0]           r_cmd_vpn;
    logic [8:0]            r_cmd_upd_asid;
    logic [31:0]           r_cmd_content;
    logic [31:0]           r_cmd_vaddr;
    logic [ASID_WIDTH-1:0] r_cmd_asid;
    logic                  r_cmd_id;

    logic                  r_resp_valid;
    logic                  r_resp_id;
    logic                  r_resp_hit;
    logic                  r_resp_is_4M;
    logic [31:0]           r_resp_content;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic                  w_idle;
    logic                  w_flush_want;
    logic                  w_grant_upd;
    logic                  w_grant_lu;
    logic                  w_lu_id;
    logic [31:0]           w_lu_vaddr;
    logic [ASID_WIDTH-1:0] w_lu_asid;

    // A same-cycle flush request competes immediately so it outranks an update.
    assign w_idle       = (r_state == c_IDLE);
    assign w_flush_want = r_flush_pend | bus.flush_req_i;
    assign w_grant_upd  = w_idle & ~w_flush_want & bus.upd_valid_i;
    assign w_grant_lu   = w_idle & ~w_flush_want & ~bus.upd_valid_i & (|bus.lu_valid_i);
    assign w_lu_id      = (bus.lu_valid_i == 2'b11) ? r_rr_ptr : bus.lu_valid_i[1];
    assign w_lu_vaddr   = w_lu_id ? bus.lu_vaddr_i[63:32] : bus.lu_vaddr_i[31:0];
    assign w_lu_asid    = w_lu_id ? bus.lu_asid_i[2*ASID_WIDTH-1:ASID_WIDTH]
                                  : bus.lu_asid_i[ASID_WIDTH-1:0];

    assign bus.upd_ready_o = w_grant_upd;
    assign bus.lu_ready_o  = w_grant_lu ? (w_lu_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= c_IDLE;
            r_rr_ptr       <= 1'b0;
            r_cmd_is_4M    <= 1'b0;
            r_cmd_vpn      <= '0;
            r_cmd_upd_asid <= '0;
            r_cmd_content  <= '0;
            r_cmd_vaddr    <= '0;
            r_cmd_asid     <= '0;
            r_cmd_id       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_flush_want) begin
                        r_state <= c_FLUSH;
                    end else if (bus.upd_valid_i) begin
                        r_state        <= c_UPDATE;
                        r_cmd_is_4M    <= bus.upd_is_4M_i;
                        r_cmd_vpn      <= bus.upd_vpn_i;
                        r_cmd_upd_asid <= bus.upd_asid_i;
                        r_cmd_content  <= bus.upd_content_i;
                    end else if (|bus.lu_valid_i) begin
                        r_state     <= c_LOOKUP;
                        r_cmd_vaddr <= w_lu_vaddr;
                        r_cmd_asid  <= w_lu_asid;
                        r_cmd_id    <= w_lu_id;
                        r_rr_ptr    <= ~w_lu_id;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // A request landing in the FLUSH cycle itself keeps the flag set for a later flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flush_pend  <= 1'b0;
            r_flush_asid  <= '0;
            r_flush_vaddr <= '0;
        end else if (bus.flush_req_i) begin
            r_flush_pend  <= 1'b1;
            r_flush_asid  <= bus.flush_asid_i;
            r_flush_vaddr <= bus.flush_vaddr_i;
        end else if (r_state == c_FLUSH) begin
            r_flush_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_valid   <= 1'b0;
            r_resp_id      <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_is_4M   <= 1'b0;
            r_resp_content <= '0;
            r_hit_cnt      <= '0;
            r_miss_cnt     <= '0;
        end else if (r_state == c_LOOKUP) begin
            r_resp_valid   <= 1'b1;
            r_resp_id      <= r_cmd_id;
            r_resp_hit     <= bus.tlb_lu_hit_i;
            r_resp_is_4M   <= bus.tlb_lu_is_4M_i;
            r_resp_content <= bus.tlb_lu_hit_i ? bus.tlb_lu_content_i : 32'd0;
            if (bus.tlb_lu_hit_i) begin
                if (r_hit_cnt != c_CNT_MAX) r_hit_cnt <= r_hit_cnt + c_CNT_ONE;
            end else begin
                if (r_miss_cnt != c_CNT_MAX) r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
            end
        end else begin
            r_resp_valid   <= 1'b0;
            r_resp_id      <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_is_4M   <= 1'b0;
            r_resp_content <= '0;
        end
    end

    always_comb begin
        bus.tlb_flush_o               = 1'b0;
        bus.flush_done_o              = 1'b0;
        bus.tlb_update_o              = '0;
        bus.tlb_lu_access_o           = 1'b0;
        bus.tlb_lu_asid_o             = '0;
        bus.tlb_lu_vaddr_o            = '0;
        bus.tlb_asid_to_be_flushed_o  = '0;
        bus.tlb_vaddr_to_be_flushed_o = '0;
        case (r_state)
            c_FLUSH: begin
                bus.tlb_flush_o               = 1'b1;
                bus.flush_done_o              = 1'b1;
                bus.tlb_asid_to_be_flushed_o  = r_flush_asid;
                bus.tlb_vaddr_to_be_flushed_o = r_flush_vaddr;
            end
            c_UPDATE: begin
                bus.tlb_update_o = {1'b1, r_cmd_is_4M, r_cmd_vpn, r_cmd_upd_asid, r_cmd_content};
            end
            c_LOOKUP: begin
                bus.tlb_lu_access_o = 1'b1;
                bus.tlb_lu_asid_o   = r_cmd_asid;
                bus.tlb_lu_vaddr_o  = r_cmd_vaddr;
            end
            default: ;
        endcase
    end

    assign bus.resp_valid_o   = r_resp_valid;
    assign bus.resp_id_o      = r_resp_id;
    assign bus.resp_hit_o     = r_resp_hit;
    assign bus.resp_is_4M_o   = r_resp_is_4M;
    assign bus.resp_content_o = r_resp_content;
    assign bus.hit_cnt_o      = r_hit_cnt;
    assign bus.miss_cnt_o     = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tlb_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_port_sched
// Description : Directed self-checking bench for tlb_port_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_port_sched;

    localparam int ASID_W = 1;
    // Narrow counters so saturation is reached with a handful of lookups.
    localparam int CNT_W  = 3;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always #5 clk_i = ~clk_i;

    tlb_port_sched_if #(.ASID_WIDTH(ASID_W), .CNT_WIDTH(CNT_W)) bus ();

    tlb_port_sched #(.ASID_WIDTH(ASID_W), .CNT_WIDTH(CNT_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample;
        @(negedge clk_i);
    endtask

    task automatic clear_inputs;
        bus.flush_req_i      = 1'b0;
        bus.flush_asid_i     = '0;
        bus.flush_vaddr_i    = '0;
        bus.upd_valid_i      = 1'b0;
        bus.upd_is_4M_i      = 1'b0;
        bus.upd_vpn_i        = '0;
        bus.upd_asid_i       = '0;
        bus.upd_content_i    = '0;
        bus.lu_valid_i       = 2'b00;
        bus.lu_vaddr_i       = '0;
        bus.lu_asid_i        = '0;
        bus.tlb_lu_hit_i     = 1'b0;
        bus.tlb_lu_is_4M_i   = 1'b0;
        bus.tlb_lu_content_i = '0;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    logic [1:0]  exp_rdy [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic [62:0] exp_upd;
    int          exp_cnt;

    initial begin
        exp_upd = {1'b1, 1'b0, 20'hABCDE, 9'd1, 32'h0000_00CF};

        // reset state and a single client-0 hit
        do_reset();
        sample();
        check_vec("rst_resp_valid", bus.resp_valid_o, 0);
        check_vec("rst_hit_cnt", bus.hit_cnt_o, 0);
        check_vec("rst_miss_cnt", bus.miss_cnt_o, 0);
        check_vec("rst_tlb_access", bus.tlb_lu_access_o, 0);
        check_vec("rst_tlb_update", bus.tlb_update_o, 0);
        check_vec("rst_tlb_flush", bus.tlb_flush_o, 0);
        check_vec("rst_flush_done", bus.flush_done_o, 0);
        step();
        bus.lu_valid_i = 2'b01;
        bus.lu_vaddr_i = {32'h0, 32'h1234_5000};
        sample();
        check_vec("lu1_ready_t0", bus.lu_ready_o, 2'b01);
        step();
        bus.lu_valid_i       = 2'b00;
        bus.tlb_lu_hit_i     = 1'b1;
        bus.tlb_lu_content_i = 32'hDEAD_BEEF;
        sample();
        check_vec("lu1_access_t1", bus.tlb_lu_access_o, 1);
        check_vec("lu1_vaddr_t1", bus.tlb_lu_vaddr_o, 32'h1234_5000);
        check_vec("lu1_resp_early", bus.resp_valid_o, 0);
        step();
        sample();
        check_vec("lu1_resp_valid", bus.resp_valid_o, 1);
        check_vec("lu1_resp_id", bus.resp_id_o, 0);
        check_vec("lu1_resp_hit", bus.resp_hit_o, 1);
        check_vec("lu1_resp_content", bus.resp_content_o, 32'hDEAD_BEEF);
        check_vec("lu1_hit_cnt", bus.hit_cnt_o, 1);

        // round-robin between two persistent clients, all misses
        do_reset();
        bus.lu_valid_i       = 2'b11;
        bus.lu_vaddr_i       = {32'h2000_0000, 32'h1000_0000};
        bus.tlb_lu_hit_i     = 1'b0;
        bus.tlb_lu_content_i = 32'h0000_0055;
        for (int k = 0; k < 8; k++) begin
            sample();
            check_vec($sformatf("rr_ready_%0d", k), bus.lu_ready_o, exp_rdy[k]);
            step();
        end
        bus.lu_valid_i = 2'b00;
        sample();
        check_vec("rr_resp_valid", bus.resp_valid_o, 1);
        check_vec("rr_resp_id", bus.resp_id_o, 1);
        check_vec("rr_resp_hit", bus.resp_hit_o, 0);
        check_vec("rr_miss_content", bus.resp_content_o, 0);
        check_vec("rr_miss_cnt", bus.miss_cnt_o, 4);
        check_vec("rr_hit_cnt", bus.hit_cnt_o, 0);

        // flush, update and lookup arriving together
        do_reset();
        bus.flush_req_i   = 1'b1;
        bus.flush_asid_i  = 1'b1;
        bus.flush_vaddr_i = 32'hCAFE_0000;
        bus.upd_valid_i   = 1'b1;
        bus.upd_vpn_i     = 20'hABCDE;
        bus.upd_asid_i    = 9'd1;
        bus.upd_is_4M_i   = 1'b0;
        bus.upd_content_i = 32'h0000_00CF;
        bus.lu_valid_i    = 2'b01;
        bus.lu_vaddr_i    = {32'h0, 32'h0040_0000};
        sample();
        check_vec("mix_c0_upd_ready", bus.upd_ready_o, 0);
        check_vec("mix_c0_lu_ready", bus.lu_ready_o, 0);
        step();
        bus.flush_req_i = 1'b0;
        sample();
        check_vec("mix_c1_flush", bus.tlb_flush_o, 1);
        check_vec("mix_c1_done", bus.flush_done_o, 1);
        check_vec("mix_c1_fvaddr", bus.tlb_vaddr_to_be_flushed_o, 32'hCAFE_0000);
        check_vec("mix_c1_fasid", bus.tlb_asid_to_be_flushed_o, 1);
        check_vec("mix_c1_update", bus.tlb_update_o, 0);
        step();
        sample();
        check_vec("mix_c2_upd_ready", bus.upd_ready_o, 1);
        check_vec("mix_c2_lu_ready", bus.lu_ready_o, 0);
        check_vec("mix_c2_done", bus.flush_done_o, 0);
        check_vec("mix_c2_flush", bus.tlb_flush_o, 0);
        step();
        bus.upd_valid_i = 1'b0;
        sample();
        check_vec("mix_c3_update", bus.tlb_update_o, exp_upd);
        check_vec("mix_c3_flush", bus.tlb_flush_o, 0);
        step();
        sample();
        check_vec("mix_c4_update_off", bus.tlb_update_o, 0);
        check_vec("mix_c4_lu_ready", bus.lu_ready_o, 2'b01);
        step();
        bus.lu_valid_i       = 2'b00;
        bus.tlb_lu_hit_i     = 1'b1;
        bus.tlb_lu_content_i = 32'h0000_0011;
        sample();
        check_vec("mix_c5_access", bus.tlb_lu_access_o, 1);
        check_vec("mix_c5_vaddr", bus.tlb_lu_vaddr_o, 32'h0040_0000);
        step();
        sample();
        check_vec("mix_c6_resp", bus.resp_valid_o, 1);
        check_vec("mix_c6_content", bus.resp_content_o, 32'h0000_0011);

        // two flush requests straddling a lookup collapse into one flush
        do_reset();
        bus.lu_valid_i       = 2'b01;
        bus.lu_vaddr_i       = {32'h0, 32'h0000_1000};
        bus.tlb_lu_hit_i     = 1'b1;
        bus.tlb_lu_content_i = 32'h0000_0077;
        sample();
        check_vec("dfl_lu_ready", bus.lu_ready_o, 2'b01);
        step();
        bus.lu_valid_i    = 2'b00;
        bus.flush_req_i   = 1'b1;
        bus.flush_asid_i  = 1'b0;
        bus.flush_vaddr_i = 32'hAAAA_0000;
        sample();
        check_vec("dfl_access", bus.tlb_lu_access_o, 1);
        step();
        bus.flush_asid_i  = 1'b1;
        bus.flush_vaddr_i = 32'hBBBB_0000;
        sample();
        check_vec("dfl_resp_valid", bus.resp_valid_o, 1);
        check_vec("dfl_resp_content", bus.resp_content_o, 32'h0000_0077);
        check_vec("dfl_no_flush_yet", bus.tlb_flush_o, 0);
        step();
        bus.flush_req_i = 1'b0;
        sample();
        check_vec("dfl_flush", bus.tlb_flush_o, 1);
        check_vec("dfl_fvaddr", bus.tlb_vaddr_to_be_flushed_o, 32'hBBBB_0000);
        check_vec("dfl_fasid", bus.tlb_asid_to_be_flushed_o, 1);
        step();
        sample();
        check_vec("dfl_flush_off1", bus.tlb_flush_o, 0);
        check_vec("dfl_done_off1", bus.flush_done_o, 0);
        step();
        sample();
        check_vec("dfl_flush_off2", bus.tlb_flush_o, 0);

        // hit counter saturation
        do_reset();
        bus.tlb_lu_hit_i     = 1'b1;
        bus.tlb_lu_content_i = 32'h0000_0001;
        for (int i = 0; i < 9; i++) begin
            bus.lu_valid_i = 2'b01;
            step();
            bus.lu_valid_i = 2'b00;
            step();
            sample();
            exp_cnt = (i + 1 > 7) ? 7 : i + 1;
            check_vec($sformatf("sat_hit_cnt_%0d", i), bus.hit_cnt_o, exp_cnt);
        end
        check_vec("sat_miss_cnt", bus.miss_cnt_o, 0);

        // asynchronous reset in the middle of a lookup
        bus.lu_valid_i = 2'b01;
        bus.lu_vaddr_i = {32'h0, 32'h0000_3000};
        step();
        bus.lu_valid_i = 2'b00;
        sample();
        check_vec("arst_access_pre", bus.tlb_lu_access_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check_vec("arst_access", bus.tlb_lu_access_o, 0);
        check_vec("arst_vaddr", bus.tlb_lu_vaddr_o, 0);
        check_vec("arst_hit_cnt", bus.hit_cnt_o, 0);
        step();
        sample();
        check_vec("arst_resp_in_rst", bus.resp_valid_o, 0);
        rst_ni = 1'b1;
        step();
        sample();
        check_vec("arst_resp_after", bus.resp_valid_o, 0);
        check_vec("arst_miss_cnt", bus.miss_cnt_o, 0);
        check_vec("arst_lu_ready", bus.lu_ready_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
